// File: rtl/regs_status_snap_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : regs_snap_pkg                                               |
// | Purpose : Shared constants for the status/snapshot read responder:    |
// |           register slot addresses, handshake FSM encoding and the     |
// |           acknowledge-delay legality check.                           |
// | Ports   : none (package)                                              |
// | Rev     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package regs_snap_pkg;

  // Register slot addresses
  localparam int C_ADR_STAT = 10;
  localparam int C_ADR_ERR  = 11;
  localparam int C_ADR_FRM0 = 12;

  // Width of the acknowledge delay counter (delays 1..15)
  localparam int C_DLY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } hs_state_e;

  function automatic bit ack_dly_ok(input int dly);
    return (dly >= 1) && (dly <= 15);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regs_status_snap_evt_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : snap_evt_ctr                                                |
// | Purpose : Event counter of parameterised width. Counts INC_i pulses,  |
// |           either wrapping or saturating at all-ones (C_SAT).          |
// |           CLR_i restarts the count; a coincident INC_i counts as 1.   |
// | Ports   : CK_i clock, RST_i sync active-high reset, CLR_i sync clear, |
// |           INC_i increment strobe, CNT_o registered count.             |
// | Rev     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module snap_evt_ctr #(
  parameter int C_W   = 8,
  parameter bit C_SAT = 1'b0
) (
  input  logic           CK_i,
  input  logic           RST_i,
  input  logic           CLR_i,
  input  logic           INC_i,
  output logic [C_W-1:0] CNT_o
);

  logic [C_W-1:0] cnt_q;
  logic [C_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (CLR_i) begin
      cnt_d = C_W'(INC_i);
    end else if (INC_i) begin
      if (C_SAT && (&cnt_q)) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + C_W'(1);
      end
    end
  end

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/regs_status_snap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : regs_status_snap                                            |
// | Purpose : Read-side responder for the UART register bridge. Counts    |
// |           frame and error strobes and exposes them as byte registers  |
// |           10..15 with a coherent 32-bit frame-count snapshot.         |
// | Ports   : CK_i/RST_i clock and sync active-high reset;                |
// |           ADRs_i/RD_REQ_i read address and request level;             |
// |           RD_ACK_o acknowledge (1 = idle/data valid);                 |
// |           RDATss_o flat registered read-data bus, slot k=[k*8 +: 8];  |
// |           FRAME_STB_i / ERR_STB_i one-cycle event strobes.            |
// | Config  : REGS_SNAP_ERRCLR_EN - read of address 11 clears the error   |
// |           counter (clear-on-read). Undefined: reset-only clear.       |
// | Rev     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module regs_status_snap
  import regs_snap_pkg::*;
#(
  parameter int C_DAT_W   = 8,
  parameter int C_ADR_W   = 4,
  parameter int C_ACK_DLY = 3
) (
  input  logic                            CK_i,
  input  logic                            RST_i,
  input  logic [C_ADR_W-1:0]              ADRs_i,
  input  logic                            RD_REQ_i,
  output logic                            RD_ACK_o,
  output logic [(2**C_ADR_W)*C_DAT_W-1:0] RDATss_o,
  input  logic                            FRAME_STB_i,
  input  logic                            ERR_STB_i
);

  generate
    if (!ack_dly_ok(C_ACK_DLY) || (C_DAT_W != 8) || (C_ADR_W != 4)) begin : g_bad_cfg
      $error("regs_status_snap: unsupported parameter set");
    end
  endgenerate

  hs_state_e          state_q, state_d;
  logic [C_DLY_W-1:0] dly_q, dly_d;
  logic               req_q;
  logic               req_vld_q;
  logic               accept;
  logic               err_clr;
  logic [31:0]        frm_cnt;
  logic [7:0]         err_cnt;
  logic [31:0]        snap_q;
  logic [7:0]         err_rd_q;
  logic               frame_seen_q;
  logic               err_sat;

  // req_q only reflects a real sample of RD_REQ_i once req_vld_q is set;
  // this keeps a request held across reset from looking like a new edge.
  logic req_rise;
  assign req_rise = RD_REQ_i & ~req_q & req_vld_q;

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    accept   = 1'b0;
    RD_ACK_o = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (req_rise) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
          dly_d   = C_DLY_W'(C_ACK_DLY - 1);
        end
      end
      ST_BUSY: begin
        RD_ACK_o = 1'b0;
        if (dly_q == '0) begin
          state_d = RD_REQ_i ? ST_HOLD : ST_IDLE;
        end else begin
          dly_d = dly_q - C_DLY_W'(1);
        end
      end
      ST_HOLD: begin
        if (!RD_REQ_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef REGS_SNAP_ERRCLR_EN
  assign err_clr = accept && (ADRs_i == C_ADR_W'(C_ADR_ERR));
`else
  assign err_clr = 1'b0;
`endif

  snap_evt_ctr #(.C_W(32), .C_SAT(1'b0)) u_frm_ctr (
    .CK_i  (CK_i),
    .RST_i (RST_i),
    .CLR_i (1'b0),
    .INC_i (FRAME_STB_i),
    .CNT_o (frm_cnt)
  );

  snap_evt_ctr #(.C_W(8), .C_SAT(1'b1)) u_err_ctr (
    .CK_i  (CK_i),
    .RST_i (RST_i),
    .CLR_i (err_clr),
    .INC_i (ERR_STB_i),
    .CNT_o (err_cnt)
  );

  assign err_sat = &err_cnt;

  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state_q      <= ST_IDLE;
      dly_q        <= '0;
      req_q        <= 1'b0;
      req_vld_q    <= 1'b0;
      snap_q       <= '0;
      err_rd_q     <= '0;
      frame_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      req_q        <= RD_REQ_i;
      if (!RD_REQ_i) begin
        req_vld_q <= 1'b1;
      end
      frame_seen_q <= frame_seen_q | FRAME_STB_i;
      if (accept) begin
        // Error byte is the pre-edge count, so a clear-on-read returns it.
        err_rd_q <= err_cnt;
        // Snapshot includes a frame strobe landing on the acceptance edge.
        if (ADRs_i == C_ADR_W'(C_ADR_FRM0)) begin
          snap_q <= frm_cnt + 32'(FRAME_STB_i);
        end
      end
    end
  end

  always_comb begin
    RDATss_o = '0;
    RDATss_o[C_ADR_STAT*C_DAT_W +: 8]     = {6'b0, err_sat, frame_seen_q};
    RDATss_o[C_ADR_ERR*C_DAT_W +: 8]      = err_rd_q;
    RDATss_o[C_ADR_FRM0*C_DAT_W +: 8]     = snap_q[7:0];
    RDATss_o[(C_ADR_FRM0+1)*C_DAT_W +: 8] = snap_q[15:8];
    RDATss_o[(C_ADR_FRM0+2)*C_DAT_W +: 8] = snap_q[23:16];
    RDATss_o[(C_ADR_FRM0+3)*C_DAT_W +: 8] = snap_q[31:24];
  end

endmodule
`default_nettype wire

// File: tb/tb_regs_status_snap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_regs_status_snap                                         |
// | Purpose : Directed self-checking bench for regs_status_snap.          |
// | Config  : honours REGS_SNAP_ERRCLR_EN for clear-on-read expectations. |
// | Rev     : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_regs_status_snap;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   adr = '0;
  logic         req = 1'b0;
  logic         frm = 1'b0;
  logic         err = 1'b0;
  logic         ack;
  logic [127:0] rdat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regs_status_snap #(.C_DAT_W(8), .C_ADR_W(4), .C_ACK_DLY(3)) dut (
    .CK_i        (clk),
    .RST_i       (rst),
    .ADRs_i      (adr),
    .RD_REQ_i    (req),
    .RD_ACK_o    (ack),
    .RDATss_o    (rdat),
    .FRAME_STB_i (frm),
    .ERR_STB_i   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] slot(input int k);
    return rdat[k*8 +: 8];
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_frm(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frm = 1'b1;
      @(negedge clk); frm = 1'b0;
    end
  endtask

  task automatic pulse_err(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); err = 1'b1;
      @(negedge clk); err = 1'b0;
    end
  endtask

  // Full read: returns number of sampled cycles with ACK low (bounded).
  task automatic do_read(input logic [3:0] a, output int lo);
    @(negedge clk); adr = a; req = 1'b1; lo = 0;
    @(negedge clk);
    while (ack == 1'b0 && lo < 50) begin
      lo++;
      @(negedge clk);
    end
    req = 1'b0;
    step(2);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lo;
    int edges;
    logic prev;

    step(3); rst = 1'b0; step(2);
    check("rst_ack", {31'b0, ack}, 32'd1);
    check("rst_rdat", {31'b0, |rdat}, 32'd0);

    // Five frames, snapshot read
    pulse_frm(5);
    check("stat_seen", {24'b0, slot(10)}, 32'h01);
    do_read(4'd12, lo);
    check("lat_rd12", lo, 32'd3);
    check("frm5_b0", {24'b0, slot(12)}, 32'h05);
    check("frm5_hi", {8'b0, slot(15), slot(14), slot(13)}, 32'h0);

    // Count to 255, snapshot, then one more frame: byte 1 must hold
    pulse_frm(250);
    do_read(4'd12, lo);
    check("frm255_b0", {24'b0, slot(12)}, 32'hFF);
    check("frm255_b1", {24'b0, slot(13)}, 32'h00);
    pulse_frm(1);
    do_read(4'd13, lo);
    check("hold_b1", {24'b0, slot(13)}, 32'h00);
    check("hold_b0", {24'b0, slot(12)}, 32'hFF);
    do_read(4'd12, lo);
    check("frm256_b0", {24'b0, slot(12)}, 32'h00);
    check("frm256_b1", {24'b0, slot(13)}, 32'h01);

    // Error saturation
    pulse_err(300);
    check("stat_sat", {24'b0, slot(10)}, 32'h03);
    do_read(4'd11, lo);
    check("err_rd1", {24'b0, slot(11)}, 32'hFF);
`ifdef REGS_SNAP_ERRCLR_EN
    check("stat_clr", {24'b0, slot(10)}, 32'h01);
    do_read(4'd11, lo);
    check("err_rd2", {24'b0, slot(11)}, 32'h00);
`else
    check("stat_noclr", {24'b0, slot(10)}, 32'h03);
    do_read(4'd11, lo);
    check("err_rd2", {24'b0, slot(11)}, 32'hFF);
`endif

    // Request level held high: one ACK-low pulse only
    @(negedge clk); adr = 4'd10; req = 1'b1;
    lo = 0; edges = 0; prev = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ack) lo++;
      if (prev && !ack) edges++;
      prev = ack;
    end
    check("held_lo", lo, 32'd3);
    check("held_pulses", edges, 32'd1);
    req = 1'b0; step(2);
    check("held_ack_end", {31'b0, ack}, 32'd1);

    // Request dropped during BUSY
    @(negedge clk); req = 1'b1;
    @(negedge clk);
    check("drop_busy", {31'b0, ack}, 32'd0);
    req = 1'b0;
    step(3);
    check("drop_ack", {31'b0, ack}, 32'd1);
    do_read(4'd10, lo);
    check("drop_relat", lo, 32'd3);

    // Wrap: preload the frame counter to all-ones
    @(negedge clk); force dut.u_frm_ctr.cnt_q = 32'hFFFF_FFFF;
    @(negedge clk); release dut.u_frm_ctr.cnt_q;
    do_read(4'd12, lo);
    check("frm_max", {slot(15), slot(14), slot(13), slot(12)}, 32'hFFFF_FFFF);
    pulse_frm(1);
    do_read(4'd12, lo);
    check("frm_wrap", {slot(15), slot(14), slot(13), slot(12)}, 32'h0);
    check("seen_wrap", {31'b0, rdat[80]}, 32'd1);

    // Reset in BUSY with the request still high
    @(negedge clk); adr = 4'd12; req = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'b0, ack}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ack", {31'b0, ack}, 32'd1);
    check("rst_mid_rdat", {31'b0, |rdat}, 32'd0);
    rst = 1'b0;
    lo = 0;
    repeat (10) begin
      @(negedge clk);
      if (!ack) lo++;
    end
    check("no_reaccept", lo, 32'd0);
    req = 1'b0; step(2);
    do_read(4'd12, lo);
    check("post_rst_lat", lo, 32'd3);
    check("post_rst_b0", {24'b0, slot(12)}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regs_status_snap.md
# regs_status_snap

Read-side responder for the UART register bridge: consumes the bridge's `ADRs`/`RD_REQ` outputs and supplies its `RDATss`/`RD_ACK` inputs. It counts video frame strobes and error strobes and presents them as byte-wide read-only registers 10–15. A 32-bit frame count is snapshotted coherently, so a multi-byte UART read never tears. Sits between the video timing/error sources and the register bridge in the top level.

## Interface
Parameters:
- `C_DAT_W`, 8, register byte width; only 8 is supported.
- `C_ADR_W`, 4, register address width; 16 slots.
- `C_ACK_DLY`, 3, cycles from accepted request to `RD_ACK_o` high; legal range 1–15.

Ports (one clock; reset is synchronous and active-high):
- `CK_i`, in, 1, clock.
- `RST_i`, in, 1, synchronous active-high reset.
- `ADRs_i`, in, `C_ADR_W`, read address from the bridge; valid while `RD_REQ_i` is high.
- `RD_REQ_i`, in, 1, read request level from the bridge.
- `RD_ACK_o`, out, 1, read acknowledge: 1 = data valid or idle, 0 = busy.
- `RDATss_o`, out, `(2**C_ADR_W)*C_DAT_W`, flat read-data bus; slot k is `[k*8 +: 8]`.
- `FRAME_STB_i`, in, 1, one-cycle frame (vsync) pulse.
- `ERR_STB_i`, in, 1, one-cycle error pulse.

## Operation
Register map (slots 0–9 drive 0x00):
- 10: status `{6'b0, err_sat, frame_seen}`, live.
- 11: error count, 8 bits, saturating at 0xFF.
- 12–15: frame snapshot bytes 0–3, little-endian.

Counters:
- The frame counter is 32 bits, increments on `FRAME_STB_i`, and wraps from 0xFFFF_FFFF to 0.
- The error counter increments on `ERR_STB_i` and holds at 0xFF.
- `frame_seen` is a sticky flag set by the first frame strobe. `err_sat` equals (error count == 0xFF).
- Neither counter has a clear other than `RST_i` (see Configuration).

Handshake FSM:
- IDLE, `RD_ACK_o`=1: on a `RD_REQ_i` rising edge (registered previous value was 0, current is 1), latch `ADRs_i`, drop ACK, load the delay counter with `C_ACK_DLY`-1, go to BUSY.
- Snapshot action on acceptance: if the address is 12, copy the live frame counter into the 32-bit snapshot. Addresses 13–15 do not re-snapshot.
- BUSY, ACK=0: decrement each cycle. At 0, set ACK=1 and go to HOLD. If `RD_REQ_i` is already low at that point, go to IDLE instead.
- HOLD, ACK=1: wait for `RD_REQ_i`=0, then go to IDLE.
- A request level that stays high is not a new request; only a rising edge is accepted.
- `ADRs_i` changes during BUSY/HOLD are ignored.

Reset values:
- `RD_ACK_o`=1, state IDLE.
- All counters, snapshot, `frame_seen` and the request edge register are 0.
- `RDATss_o` is all zeros.

## Timing
- Request edge sampled at edge n: `RD_ACK_o` is 0 after edge n and 1 after edge n+`C_ACK_DLY`.
- `RDATss_o` slot 11–15 contents are stable from edge n+1 until the next accepted request.
- `RDATss_o` is fully registered; there is no combinational path from `ADRs_i`.
- A strobe at edge m is visible in the live counters after edge m.
- A snapshot at edge n includes a frame strobe coincident with edge n.
- `RST_i` mid-transaction: return to IDLE with ACK=1 on the next edge. A still-high `RD_REQ_i` is not re-accepted until it goes low and then high again.

## Configuration
- `REGS_SNAP_ERRCLR_EN` defined:
  - An accepted read of address 11 returns the pre-clear count and clears the error counter on the acceptance edge.
  - If `ERR_STB_i` coincides with that edge, the counter becomes 1.
  - `err_sat` clears along with the count.
- `REGS_SNAP_ERRCLR_EN` undefined: the error counter is only cleared by `RST_i`.

## Structure
- Package `regs_snap_pkg`:
  - address constants `C_ADR_STAT`=10, `C_ADR_ERR`=11, `C_ADR_FRM0`=12;
  - FSM state encoding IDLE/BUSY/HOLD;
  - the `C_ACK_DLY` range check.
- Sub-module `snap_evt_ctr`: parameterised width, with a wrap/saturate select and a synchronous clear. It is instanced twice, 32-bit wrap and 8-bit saturate.

## Test plan
- Reset, then an idle check: `RD_ACK_o`=1 and `RDATss_o`=0. Then 5 frame strobes and a read of address 12: ACK is low for 3 cycles, slot 12=0x05 and slots 13–15=0x00.
- Preset the frame counter to 0x0000_00FF via 255 strobes. Read address 12, apply 1 strobe, then read address 13: slot 13 is still 0x00 (snapshot held); a re-read of 12 gives slot 12=0x00 and slot 13=0x01.
- 300 error strobes: slot 11=0xFF and slot 10 bit1=1. With ERRCLR_EN, a read of 11 returns 0xFF and the next read returns 0x00.
- `RD_REQ_i` held high for 20 cycles: exactly one ACK low pulse. Dropping REQ during BUSY: ACK returns to 1 and the FSM enters IDLE.
- `RST_i` asserted in BUSY: ACK=1 and all slots are 0 on the next edge. REQ still high gives no new acceptance.
- Frame counter at 0xFFFF_FFFF plus 1 strobe: the snapshot reads 0x00 in slots 12–15 and `frame_seen` stays 1.
